// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory stage:
// request/writeback bundles, FSM states and funct3 encodings.
package mem_access_unit_pkg;

   localparam int cDataWidth      = 32;
   localparam int cRegSelBitW     = 5;
   localparam int cRespTimeoutDef = 15;

   localparam logic [2:0] cF3Byte  = 3'd0;
   localparam logic [2:0] cF3Half  = 3'd1;
   localparam logic [2:0] cF3Word  = 3'd2;
   localparam logic [2:0] cF3ByteU = 3'd4;
   localparam logic [2:0] cF3HalfU = 3'd5;

   typedef struct packed {
      logic                   memRead;
      logic                   memWrite;
      logic [cDataWidth-1:0]  addr;
      logic [cRegSelBitW-1:0] rdAddr;
      logic [2:0]             funct3;
      logic [cDataWidth-1:0]  storeData;
   } tMemReq;

   typedef struct packed {
      logic [cRegSelBitW-1:0] rdAddr;
      logic [cDataWidth-1:0]  data;
   } tMemWb;

   typedef enum logic [1:0] {
      eMemIdle,
      eMemReq,
      eMemResp,
      eMemWb
   } tMemState;

   function automatic logic f3_illegal(logic is_load, logic [2:0] f3);
      if (is_load) begin
         return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      return f3 > cF3Word;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory stage bus bundle: ALU request handshake, data-memory
// bus and register writeback. slave = the unit, master = its environment.
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic                   iReqValid;
   logic                   oReqReady;
   tMemReq                 iReq;
   logic                   oDmemReq;
   logic                   iDmemGnt;
   logic                   oDmemWe;
   logic [cDataWidth-1:0]  oDmemAddr;
   logic [3:0]             oDmemBe;
   logic [cDataWidth-1:0]  oDmemWdata;
   logic                   iDmemRvalid;
   logic [cDataWidth-1:0]  iDmemRdata;
   logic                   oWbValid;
   logic [cRegSelBitW-1:0] oWbRdAddr;
   logic [cDataWidth-1:0]  oWbData;
   logic                   oErr;

   modport slave (
      input  iReqValid, iReq, iDmemGnt, iDmemRvalid, iDmemRdata,
      output oReqReady, oDmemReq, oDmemWe, oDmemAddr, oDmemBe,
      output oDmemWdata, oWbValid, oWbRdAddr, oWbData, oErr
   );

   modport master (
      output iReqValid, iReq, iDmemGnt, iDmemRvalid, iDmemRdata,
      input  oReqReady, oDmemReq, oDmemWe, oDmemAddr, oDmemBe,
      input  oDmemWdata, oWbValid, oWbRdAddr, oWbData, oErr
   );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data
// and load byte/half extraction with sign or zero extension.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]            funct3,
   input  logic [1:0]            off,
   input  logic [cDataWidth-1:0] store_data,
   input  logic [cDataWidth-1:0] rdata,
   output logic [3:0]            be,
   output logic [cDataWidth-1:0] wdata,
   output logic [cDataWidth-1:0] ld_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[7:0];
      unique case (off)
         2'd0: byte_v = rdata[7:0];
         2'd1: byte_v = rdata[15:8];
         2'd2: byte_v = rdata[23:16];
         2'd3: byte_v = rdata[31:24];
         default: byte_v = rdata[7:0];
      endcase
      half_v = off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      be      = 4'b0000;
      wdata   = '0;
      ld_data = '0;
      unique case (funct3)
         cF3Byte: begin
            be      = 4'b0001 << off;
            wdata   = {4{store_data[7:0]}};
            ld_data = {{24{byte_v[7]}}, byte_v};
         end
         cF3ByteU: begin
            be      = 4'b0001 << off;
            ld_data = {24'h0, byte_v};
         end
         cF3Half: begin
            be      = 4'b0011 << off;
            wdata   = {2{store_data[15:0]}};
            ld_data = {{16{half_v[15]}}, half_v};
         end
         cF3HalfU: begin
            be      = 4'b0011 << off;
            ld_data = {16'h0, half_v};
         end
         cF3Word: begin
            be      = 4'hF;
            wdata   = store_data;
            ld_data = rdata;
         end
         default: begin
            be = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: accepts one load/store, runs the dmem req/gnt/rvalid bus
// and returns load writebacks. MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int cRespTimeout = cRespTimeoutDef
) (
   input logic               iClk,
   input logic               iRstn,
   mem_access_unit_if.slave  bus
);

   localparam int cCntW = $clog2(cRespTimeout + 1);

   tMemState         state_q, state_d;
   tMemReq           req_q, req_d;
   tMemWb            wb_q, wb_d;
   logic [cCntW-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             ready;
   logic             accept;
   logic             in_req;
   logic             is_ld;
   logic             is_st;
   logic             both;
   logic             misalign;
   logic [1:0]       off_in;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [31:0]      ld_data;

   mem_lane_align u_lane (
      .funct3     (req_q.funct3),
      .off        (req_q.addr[1:0]),
      .store_data (req_q.storeData),
      .rdata      (bus.iDmemRdata),
      .be         (be),
      .wdata      (wdata),
      .ld_data    (ld_data)
   );

   assign ready  = (state_q == eMemIdle) & iRstn;
   assign accept = bus.iReqValid & ready;
   assign is_ld  = bus.iReq.memRead & ~bus.iReq.memWrite;
   assign is_st  = bus.iReq.memWrite & ~bus.iReq.memRead;
   assign both   = bus.iReq.memRead & bus.iReq.memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign =
      ((bus.iReq.funct3[1:0] == 2'b01) && bus.iReq.addr[0]) ||
      ((bus.iReq.funct3 == cF3Word) && (bus.iReq.addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // natural alignment is forced; with trapping enabled it never changes anything
   always_comb begin
      off_in = bus.iReq.addr[1:0];
      if (bus.iReq.funct3[1:0] == 2'b01) begin
         off_in[0] = 1'b0;
      end else if (bus.iReq.funct3 == cF3Word) begin
         off_in = 2'b00;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      wb_d    = wb_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      unique case (state_q)
         eMemIdle: begin
            if (accept) begin
               if (both || misalign ||
                   (is_ld && f3_illegal(1'b1, bus.iReq.funct3)) ||
                   (is_st && f3_illegal(1'b0, bus.iReq.funct3))) begin
                  err_d = 1'b1;
               end else if (is_ld || is_st) begin
                  req_d           = bus.iReq;
                  req_d.addr[1:0] = off_in;
                  state_d         = eMemReq;
               end
            end
         end
         eMemReq: begin
            if (bus.iDmemGnt) begin
               cnt_d   = '0;
               state_d = eMemResp;
            end
         end
         eMemResp: begin
            if (bus.iDmemRvalid) begin
               if (req_q.memRead) begin
                  wb_d.rdAddr = req_q.rdAddr;
                  wb_d.data   = ld_data;
                  state_d     = eMemWb;
               end else begin
                  state_d = eMemIdle;
               end
            end else if (cnt_q == cCntW'(cRespTimeout - 1)) begin
               err_d   = 1'b1;
               state_d = eMemIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         eMemWb: begin
            state_d = eMemIdle;
         end
         default: begin
            state_d = eMemIdle;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRstn) begin
         state_q <= eMemIdle;
         req_q   <= '0;
         wb_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         wb_q    <= wb_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign in_req = (state_q == eMemReq);

   assign bus.oReqReady  = ready;
   assign bus.oDmemReq   = in_req;
   assign bus.oDmemWe    = in_req & req_q.memWrite;
   assign bus.oDmemAddr  = in_req ? {req_q.addr[31:2], 2'b00} : '0;
   assign bus.oDmemBe    = in_req ? be : 4'b0000;
   assign bus.oDmemWdata = (in_req & req_q.memWrite) ? wdata : '0;
   assign bus.oWbValid   = (state_q == eMemWb) && (wb_q.rdAddr != '0);
   assign bus.oWbRdAddr  = (state_q == eMemWb) ? wb_q.rdAddr : '0;
   assign bus.oWbData    = wb_q.data;
   assign bus.oErr       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores,
// bus stalls, timeout, illegal requests and reset mid-access.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int K_BUS = 0;
   localparam int K_WB  = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int          kind;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rstn;
   int   cyc;
   int   errors;
   int   checks;
   int   wb_cnt;
   int   last_wb_cyc;
   int   last_err_cyc;
   logic last_err_ready;
   exp_t exp_q[$];

   mem_access_unit_if bus_if ();

   mem_access_unit dut (
      .iClk  (clk),
      .iRstn (rstn),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, req);
      end
   endfunction

   function automatic tMemReq mk(logic rd, logic wr, logic [31:0] a,
                                 logic [4:0] r, logic [2:0] f3,
                                 logic [31:0] sd);
      tMemReq m;
      m.memRead   = rd;
      m.memWrite  = wr;
      m.addr      = a;
      m.rdAddr    = r;
      m.funct3    = f3;
      m.storeData = sd;
      return m;
   endfunction

   function automatic exp_t e_bus(logic we, logic [31:0] a, logic [3:0] be,
                                  logic [31:0] wd);
      exp_t e;
      e = '{kind: K_BUS, we: we, addr: a, be: be, wdata: wd, rd: '0, data: '0};
      return e;
   endfunction

   function automatic exp_t e_wb(logic [4:0] r, logic [31:0] d);
      exp_t e;
      e = '{kind: K_WB, we: 1'b0, addr: '0, be: '0, wdata: '0, rd: r, data: d};
      return e;
   endfunction

   function automatic exp_t e_err();
      exp_t e;
      e = '{kind: K_ERR, we: 1'b0, addr: '0, be: '0, wdata: '0, rd: '0, data: '0};
      return e;
   endfunction

   // monitor: pops one expectation per observed DUT event
   always @(negedge clk) begin
      exp_t e;
      if (bus_if.oDmemReq && bus_if.iDmemGnt) begin
         if (exp_q.size() == 0) begin
            chk("bus_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("bus_kind", e.kind, K_BUS);
            chk("bus_we", {31'd0, bus_if.oDmemWe}, {31'd0, e.we});
            chk("bus_addr", bus_if.oDmemAddr, e.addr);
            chk("bus_be", {28'd0, bus_if.oDmemBe}, {28'd0, e.be});
            chk("bus_wdata", bus_if.oDmemWdata, e.wdata);
         end
      end
      if (bus_if.oWbValid) begin
         wb_cnt++;
         last_wb_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_kind", e.kind, K_WB);
            chk("wb_rd", {27'd0, bus_if.oWbRdAddr}, {27'd0, e.rd});
            chk("wb_data", bus_if.oWbData, e.data);
         end
      end
      if (bus_if.oErr) begin
         last_err_cyc   = cyc;
         last_err_ready = bus_if.oReqReady;
         if (exp_q.size() == 0) begin
            chk("err_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("err_kind", e.kind, K_ERR);
         end
      end
   end

   task automatic chk_bus(input exp_t eb);
      chk("req_held", {31'd0, bus_if.oDmemReq}, 32'd1);
      chk("req_we", {31'd0, bus_if.oDmemWe}, {31'd0, eb.we});
      chk("req_addr", bus_if.oDmemAddr, eb.addr);
      chk("req_be", {28'd0, bus_if.oDmemBe}, {28'd0, eb.be});
      chk("req_wdata", bus_if.oDmemWdata, eb.wdata);
   endtask

   // rw < 0: rvalid never returns
   task automatic run_op(input tMemReq r, input bit has_bus, input exp_t eb,
                         input int gw, input int rw,
                         input logic [31:0] rdata, output int t0);
      @(posedge clk); #1;
      bus_if.iReqValid = 1'b1;
      bus_if.iReq      = r;
      t0 = cyc;
      chk("ready_accept", {31'd0, bus_if.oReqReady}, 32'd1);
      @(posedge clk); #1;
      bus_if.iReqValid = 1'b0;
      bus_if.iReq      = '0;
      if (has_bus) begin
         for (int k = 0; k < gw; k++) begin
            chk_bus(eb);
            @(posedge clk); #1;
         end
         chk_bus(eb);
         bus_if.iDmemGnt = 1'b1;
         @(posedge clk); #1;
         bus_if.iDmemGnt = 1'b0;
         if (rw >= 0) begin
            for (int k = 0; k < rw; k++) begin
               @(posedge clk); #1;
            end
            bus_if.iDmemRvalid = 1'b1;
            bus_if.iDmemRdata  = rdata;
            @(posedge clk); #1;
            bus_if.iDmemRvalid = 1'b0;
            bus_if.iDmemRdata  = '0;
         end else begin
            for (int k = 0; k < 20; k++) begin
               @(posedge clk); #1;
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int   t0;
      int   wb_before;
      exp_t eb;
      errors = 0;
      checks = 0;
      wb_cnt = 0;
      last_wb_cyc = -1;
      last_err_cyc = -1;
      last_err_ready = 1'b0;
      rstn = 1'b0;
      bus_if.iReqValid   = 1'b0;
      bus_if.iReq        = '0;
      bus_if.iDmemGnt    = 1'b0;
      bus_if.iDmemRvalid = 1'b0;
      bus_if.iDmemRdata  = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, bus_if.oReqReady}, 32'd0);
      chk("rst_req", {31'd0, bus_if.oDmemReq}, 32'd0);
      chk("rst_wb", {31'd0, bus_if.oWbValid}, 32'd0);
      chk("rst_err", {31'd0, bus_if.oErr}, 32'd0);
      chk("rst_addr", bus_if.oDmemAddr, 32'd0);
      chk("rst_wbdata", bus_if.oWbData, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", {31'd0, bus_if.oReqReady}, 32'd1);

      // LW, minimum latency
      eb = e_bus(1'b0, 32'h100, 4'hF, 32'h0);
      exp_q.push_back(eb);
      exp_q.push_back(e_wb(5'd5, 32'hDEADBEEF));
      run_op(mk(1, 0, 32'h100, 5'd5, cF3Word, 0), 1, eb, 0, 0,
             32'hDEADBEEF, t0);
      chk("lw_latency", last_wb_cyc, t0 + 3);

      // LB / LBU at offset 3
      eb = e_bus(1'b0, 32'h100, 4'b1000, 32'h0);
      exp_q.push_back(eb);
      exp_q.push_back(e_wb(5'd6, 32'hFFFFFF80));
      run_op(mk(1, 0, 32'h103, 5'd6, cF3Byte, 0), 1, eb, 0, 0,
             32'h80112233, t0);
      exp_q.push_back(eb);
      exp_q.push_back(e_wb(5'd7, 32'h00000080));
      run_op(mk(1, 0, 32'h103, 5'd7, cF3ByteU, 0), 1, eb, 0, 1,
             32'h80112233, t0);

      // LH upper half, LHU lower half
      eb = e_bus(1'b0, 32'h100, 4'b1100, 32'h0);
      exp_q.push_back(eb);
      exp_q.push_back(e_wb(5'd10, 32'hFFFF8011));
      run_op(mk(1, 0, 32'h102, 5'd10, cF3Half, 0), 1, eb, 0, 0,
             32'h80112233, t0);
      eb = e_bus(1'b0, 32'h100, 4'b0011, 32'h0);
      exp_q.push_back(eb);
      exp_q.push_back(e_wb(5'd11, 32'h00002233));
      run_op(mk(1, 0, 32'h100, 5'd11, cF3HalfU, 0), 1, eb, 0, 0,
             32'h80112233, t0);

      // SH and SB: no writeback
      wb_before = wb_cnt;
      eb = e_bus(1'b1, 32'h100, 4'b1100, 32'hABCDABCD);
      exp_q.push_back(eb);
      run_op(mk(0, 1, 32'h102, 5'd3, cF3Half, 32'h0000ABCD), 1, eb, 0, 0,
             0, t0);
      eb = e_bus(1'b1, 32'h100, 4'b0010, 32'h5A5A5A5A);
      exp_q.push_back(eb);
      run_op(mk(0, 1, 32'h101, 5'd3, cF3Byte, 32'h1234565A), 1, eb, 0, 2,
             0, t0);
      chk("store_no_wb", wb_cnt, wb_before);
      chk("store_idle", {31'd0, bus_if.oReqReady}, 32'd1);

      // SW with grant withheld 4 cycles
      eb = e_bus(1'b1, 32'h204, 4'hF, 32'h12345678);
      exp_q.push_back(eb);
      run_op(mk(0, 1, 32'h204, 5'd0, cF3Word, 32'h12345678), 1, eb, 4, 0,
             0, t0);

      // LW to x0: access performed, writeback suppressed
      wb_before = wb_cnt;
      eb = e_bus(1'b0, 32'h208, 4'hF, 32'h0);
      exp_q.push_back(eb);
      run_op(mk(1, 0, 32'h208, 5'd0, cF3Word, 0), 1, eb, 0, 0,
             32'h11111111, t0);
      chk("x0_no_wb", wb_cnt, wb_before);

      // response timeout
      eb = e_bus(1'b0, 32'h300, 4'hF, 32'h0);
      exp_q.push_back(eb);
      exp_q.push_back(e_err());
      run_op(mk(1, 0, 32'h300, 5'd9, cF3Word, 0), 1, eb, 0, -1, 0, t0);
      chk("timeout_cycle", last_err_cyc, t0 + 2 + 15);
      chk("timeout_ready", {31'd0, last_err_ready}, 32'd1);

      // illegal requests
      exp_q.push_back(e_err());
      run_op(mk(1, 0, 32'h100, 5'd4, 3'd3, 0), 0, eb, 0, 0, 0, t0);
      chk("ill_ld_cycle", last_err_cyc, t0 + 1);
      exp_q.push_back(e_err());
      run_op(mk(0, 1, 32'h100, 5'd4, cF3ByteU, 0), 0, eb, 0, 0, 0, t0);
      chk("ill_st_cycle", last_err_cyc, t0 + 1);
      exp_q.push_back(e_err());
      run_op(mk(1, 1, 32'h100, 5'd4, cF3Word, 0), 0, eb, 0, 0, 0, t0);
      chk("both_cycle", last_err_cyc, t0 + 1);

      // no-op request, then stray gnt/rvalid in IDLE
      wb_before = wb_cnt;
      run_op(mk(0, 0, 32'h100, 5'd4, cF3Word, 0), 0, eb, 0, 0, 0, t0);
      bus_if.iDmemGnt    = 1'b1;
      bus_if.iDmemRvalid = 1'b1;
      @(posedge clk); #1;
      bus_if.iDmemGnt    = 1'b0;
      bus_if.iDmemRvalid = 1'b0;
      @(posedge clk); #1;
      chk("noop_ready", {31'd0, bus_if.oReqReady}, 32'd1);
      chk("noop_no_wb", wb_cnt, wb_before);

      // misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
      exp_q.push_back(e_err());
      run_op(mk(1, 0, 32'h101, 5'd8, cF3Word, 0), 0, eb, 0, 0, 0, t0);
      chk("misal_err", last_err_cyc, t0 + 1);
`else
      eb = e_bus(1'b0, 32'h100, 4'hF, 32'h0);
      exp_q.push_back(eb);
      exp_q.push_back(e_wb(5'd8, 32'hCAFEF00D));
      run_op(mk(1, 0, 32'h101, 5'd8, cF3Word, 0), 1, eb, 0, 0,
             32'hCAFEF00D, t0);
`endif

      // reset during RESP, late rvalid dropped
      wb_before = wb_cnt;
      eb = e_bus(1'b0, 32'h400, 4'hF, 32'h0);
      exp_q.push_back(eb);
      @(posedge clk); #1;
      bus_if.iReqValid = 1'b1;
      bus_if.iReq      = mk(1, 0, 32'h400, 5'd12, cF3Word, 0);
      @(posedge clk); #1;
      bus_if.iReqValid = 1'b0;
      bus_if.iReq      = '0;
      bus_if.iDmemGnt  = 1'b1;
      @(posedge clk); #1;
      bus_if.iDmemGnt  = 1'b0;
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_ready", {31'd0, bus_if.oReqReady}, 32'd0);
      chk("mid_rst_req", {31'd0, bus_if.oDmemReq}, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_idle", {31'd0, bus_if.oReqReady}, 32'd1);
      bus_if.iDmemRvalid = 1'b1;
      bus_if.iDmemRdata  = 32'h55AA55AA;
      @(posedge clk); #1;
      bus_if.iDmemRvalid = 1'b0;
      bus_if.iDmemRdata  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("late_rvalid_dropped", wb_cnt, wb_before);

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
